// File: rtl/alu_req_arbiter_if.sv
// rtl/alu_req_arbiter_if.sv - request/response/ALU bundle for alu_req_arbiter
// Optional err signals exist only when ALU_ARB_ILLEGAL_OP_EN is defined.
interface alu_req_arbiter_if #(
   parameter int WIDTH = 4
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [1:0]       req0_sel;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [1:0]       req1_sel;

   logic             resp0_valid;
   logic             resp0_ready;
   logic [WIDTH-1:0] resp0_result;
   logic             resp1_valid;
   logic             resp1_ready;
   logic [WIDTH-1:0] resp1_result;
`ifdef ALU_ARB_ILLEGAL_OP_EN
   logic             resp0_err;
   logic             resp1_err;
`endif

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [1:0]       alu_sel;
   logic [WIDTH-1:0] alu_result;
   logic             busy;

   modport slave (
`ifdef ALU_ARB_ILLEGAL_OP_EN
      output resp0_err, resp1_err,
`endif
      input  req0_valid, req0_a, req0_b, req0_sel,
      input  req1_valid, req1_a, req1_b, req1_sel,
      output req0_ready, req1_ready,
      output resp0_valid, resp0_result, resp1_valid, resp1_result,
      input  resp0_ready, resp1_ready,
      output alu_a, alu_b, alu_sel, busy,
      input  alu_result
   );

   modport master (
`ifdef ALU_ARB_ILLEGAL_OP_EN
      input  resp0_err, resp1_err,
`endif
      output req0_valid, req0_a, req0_b, req0_sel,
      output req1_valid, req1_a, req1_b, req1_sel,
      input  req0_ready, req1_ready,
      input  resp0_valid, resp0_result, resp1_valid, resp1_result,
      output resp0_ready, resp1_ready,
      input  alu_a, alu_b, alu_sel, busy,
      output alu_result
   );
endinterface

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin front end sharing one ALU between two requesters
// ALU_ARB_ILLEGAL_OP_EN: sel=11 bypasses the ALU and returns result 0 with an err flag.
module alu_req_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_req_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             grant_q, grant_d;
   logic             last_grant_q, last_grant_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [1:0]       alu_sel_q, alu_sel_d;
`ifdef ALU_ARB_ILLEGAL_OP_EN
   logic             err_q, err_d;
`endif

   logic             winner;
   logic             accept;
   logic             illegal;
   logic             resp_take;
   logic [WIDTH-1:0] win_a;
   logic [WIDTH-1:0] win_b;
   logic [1:0]       win_sel;

   // A lone request always wins; on contention the one that did not go last wins.
   always_comb begin
      winner = bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) begin
         winner = ~last_grant_q;
      end
      win_a   = winner ? bus.req1_a   : bus.req0_a;
      win_b   = winner ? bus.req1_b   : bus.req0_b;
      win_sel = winner ? bus.req1_sel : bus.req0_sel;
   end

   assign accept    = rst_n && (state_q == S_IDLE) && (bus.req0_valid || bus.req1_valid);
   assign resp_take = (state_q == S_RESP) && (grant_q ? bus.resp1_ready : bus.resp0_ready);

`ifdef ALU_ARB_ILLEGAL_OP_EN
   assign illegal = (win_sel == 2'b11);
`else
   assign illegal = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      result_d     = result_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_sel_d    = alu_sel_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      err_d        = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               grant_d = winner;
               if (illegal) begin
                  // Never reaches the ALU, so the ALU-side registers keep the last issued op.
                  state_d  = S_RESP;
                  result_d = '0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                  err_d    = 1'b1;
`endif
               end else begin
                  state_d   = S_EXEC;
                  alu_a_d   = win_a;
                  alu_b_d   = win_b;
                  alu_sel_d = win_sel;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                  err_d     = 1'b0;
`endif
               end
            end
         end
         S_EXEC: begin
            result_d = bus.alu_result;
            state_d  = S_RESP;
         end
         S_RESP: begin
            if (resp_take) begin
               last_grant_d = grant_q;
               state_d      = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         result_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_sel_q    <= 2'b00;
`ifdef ALU_ARB_ILLEGAL_OP_EN
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         result_q     <= result_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_sel_q    <= alu_sel_d;
`ifdef ALU_ARB_ILLEGAL_OP_EN
         err_q        <= err_d;
`endif
      end
   end

   // Response outputs derive from the async-reset state, so they drop the moment rst_n falls.
   assign bus.req0_ready   = accept && !winner;
   assign bus.req1_ready   = accept && winner;
   assign bus.resp0_valid  = (state_q == S_RESP) && !grant_q;
   assign bus.resp1_valid  = (state_q == S_RESP) && grant_q;
   assign bus.resp0_result = bus.resp0_valid ? result_q : '0;
   assign bus.resp1_result = bus.resp1_valid ? result_q : '0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
   assign bus.resp0_err    = bus.resp0_valid && err_q;
   assign bus.resp1_err    = bus.resp1_valid && err_q;
`endif
   assign bus.alu_a        = alu_a_q;
   assign bus.alu_b        = alu_b_q;
   assign bus.alu_sel      = alu_sel_q;
   assign bus.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - directed plus randomized bench for alu_req_arbiter
// Honors ALU_ARB_ILLEGAL_OP_EN when defined.
module tb_alu_req_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   alu_req_arbiter_if #(.WIDTH(4)) bus ();
   alu_req_arbiter #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

`ifdef ALU_ARB_ILLEGAL_OP_EN
   localparam bit ILLEGAL_EN = 1'b1;
`else
   localparam bit ILLEGAL_EN = 1'b0;
`endif

   function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
      case (s)
         2'b00:   return 4'((a + b) % 16);
         2'b01:   return a & b;
         2'b10:   return a | b;
         default: return 4'h0;
      endcase
   endfunction

   assign bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);

   // Transaction-level model: pending requests, last served requester, last issued ALU op.
   bit         pend [2];
   logic [3:0] pa [2];
   logic [3:0] pb [2];
   logic [1:0] ps [2];
   int         m_last;
   logic [3:0] m_alu_a;
   logic [3:0] m_alu_b;
   logic [1:0] m_alu_sel;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input int n, input bit v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
      if (n == 0) begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = s;
      end else begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = s;
      end
   endtask

   task automatic set_req(input int n, input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
      pend[n] = 1'b1; pa[n] = a; pb[n] = b; ps[n] = s;
      drive_req(n, 1'b1, a, b, s);
   endtask

   task automatic set_rready(input int n, input bit r);
      if (n == 0) bus.resp0_ready = r;
      else        bus.resp1_ready = r;
   endtask

   function automatic logic rdy(input int n);
      return (n == 0) ? bus.req0_ready : bus.req1_ready;
   endfunction

   function automatic logic rv(input int n);
      return (n == 0) ? bus.resp0_valid : bus.resp1_valid;
   endfunction

   function automatic logic [3:0] rres(input int n);
      return (n == 0) ? bus.resp0_result : bus.resp1_result;
   endfunction

`ifdef ALU_ARB_ILLEGAL_OP_EN
   function automatic logic rerr(input int n);
      return (n == 0) ? bus.resp0_err : bus.resp1_err;
   endfunction
`endif

   task automatic model_reset();
      pend[0] = 1'b0; pend[1] = 1'b0;
      m_last = 1;
      m_alu_a = 4'h0; m_alu_b = 4'h0; m_alu_sel = 2'b00;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      drive_req(0, 1'b0, 4'h0, 4'h0, 2'b00);
      drive_req(1, 1'b0, 4'h0, 4'h0, 2'b00);
      bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
      model_reset();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Called in IDLE with at least one request pending; serves exactly one op end to end.
   task automatic serve(input int hold, input int late);
      int         w;
      bit         ill;
      int         lat;
      logic [3:0] exp;
      #1;
      w   = (pend[0] && pend[1]) ? 1 - m_last : (pend[1] ? 1 : 0);
      ill = ILLEGAL_EN && (ps[w] == 2'b11);
      exp = ill ? 4'h0 : alu_fn(pa[w], pb[w], ps[w]);
      lat = ill ? 1 : 2;
      chk("ready_winner", rdy(w), 1'b1);
      chk("ready_loser", rdy(1 - w), 1'b0);
      if (!ill) begin
         m_alu_a = pa[w]; m_alu_b = pb[w]; m_alu_sel = ps[w];
      end
      tick();
      pend[w] = 1'b0;
      drive_req(w, 1'b0, pa[w], pb[w], ps[w]);
      for (int n = 0; n < 2; n++) begin
         if (late[n] && !pend[n])
            set_req(n, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      end
      for (int c = 1; c < lat; c++) begin
         #1;
         chk("exec_no_resp", rv(0) | rv(1), 1'b0);
         chk("exec_busy", bus.busy, 1'b1);
         chk("exec_ready", rdy(0) | rdy(1), 1'b0);
         tick();
      end
      #1;
      chk("resp_valid", rv(w), 1'b1);
      chk("resp_other", rv(1 - w), 1'b0);
      chk("resp_result", rres(w), exp);
`ifdef ALU_ARB_ILLEGAL_OP_EN
      chk("resp_err", rerr(w), ill);
      chk("resp_err_other", rerr(1 - w), 1'b0);
`endif
      chk("alu_a", bus.alu_a, m_alu_a);
      chk("alu_b", bus.alu_b, m_alu_b);
      chk("alu_sel", bus.alu_sel, m_alu_sel);
      set_rready(1 - w, 1'b1);
      for (int h = 0; h < hold; h++) begin
         tick();
         chk("hold_valid", rv(w), 1'b1);
         chk("hold_result", rres(w), exp);
         chk("hold_ready0", bus.req0_ready, 1'b0);
         chk("hold_ready1", bus.req1_ready, 1'b0);
      end
      set_rready(1 - w, 1'b0);
      set_rready(w, 1'b1);
      tick();
      set_rready(w, 1'b0);
      m_last = w;
      chk("idle_resp_drop", rv(w), 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      drive_req(0, 1'b0, 4'h0, 4'h0, 2'b00);
      drive_req(1, 1'b0, 4'h0, 4'h0, 2'b00);
      bus.resp0_ready = 1'b0;
      bus.resp1_ready = 1'b0;
      model_reset();
      tick();
      tick();
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_resp_valid", {bus.resp0_valid, bus.resp1_valid}, 2'b00);
      chk("rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
      chk("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, 10'h0);
      chk("rst_result", {bus.resp0_result, bus.resp1_result}, 8'h0);
      rst_n = 1'b1;
      tick();

      // 3 + 4 on requester 0
      set_req(0, 4'h3, 4'h4, 2'b00);
      serve(0, 0);
      chk("t1_idle", bus.busy, 1'b0);

      // Contention after reset: requester 0 first, then alternation.
      reset_dut();
      set_req(0, 4'hF, 4'h1, 2'b00);
      set_req(1, 4'hC, 4'hA, 2'b01);
      serve(0, 0);
      serve(0, 0);
      set_req(0, 4'h7, 4'h2, 2'b10);
      set_req(1, 4'h6, 4'h3, 2'b00);
      serve(0, 0);
      serve(0, 0);

      // Requester 1 stalls its response while requester 0 arrives late and waits.
      set_req(1, 4'h2, 4'h9, 2'b00);
      serve(5, 1);
      serve(0, 0);

      // 5 | A, then reset lands in EXEC of the next op.
      set_req(1, 4'h5, 4'hA, 2'b10);
      serve(0, 0);
      set_req(0, 4'h1, 4'h2, 2'b00);
      #1;
      chk("t4_ready0", bus.req0_ready, 1'b1);
      tick();
      drive_req(0, 1'b0, 4'h1, 4'h2, 2'b00);
      set_req(1, 4'h4, 4'h4, 2'b00);
      rst_n = 1'b0;
      #1;
      chk("t4_rst_busy", bus.busy, 1'b0);
      chk("t4_rst_resp", {bus.resp0_valid, bus.resp1_valid}, 2'b00);
      chk("t4_rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
      chk("t4_rst_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, 10'h0);
      pend[0] = 1'b0;
      m_last = 1;
      m_alu_a = 4'h0; m_alu_b = 4'h0; m_alu_sel = 2'b00;
      tick();
      rst_n = 1'b1;
      #1;
      chk("t4_no_resp", {bus.resp0_valid, bus.resp1_valid}, 2'b00);
      set_req(0, 4'h8, 4'h8, 2'b00);
      serve(0, 0);
      serve(0, 0);

      // Illegal opcode
      reset_dut();
      set_req(0, 4'h9, 4'h6, 2'b11);
      serve(0, 0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
      chk("t5_alu_a_kept", bus.alu_a, 4'h0);
      chk("t5_alu_sel_kept", bus.alu_sel, 2'b00);
`else
      chk("t5_alu_a_issued", bus.alu_a, 4'h9);
      chk("t5_alu_sel_issued", bus.alu_sel, 2'b11);
`endif

      // Randomized traffic
      for (int r = 0; r < 40; r++) begin
         for (int n = 0; n < 2; n++) begin
            if (!pend[n] && ($urandom_range(0, 1) == 1))
               set_req(n, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
         end
         if (!pend[0] && !pend[1])
            set_req(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)));
         serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
